vc_allocator: RTL

- Router-level virtual-channel allocator sitting directly downstream of the per-input-VC status buffers.
- Accepts each buffer's VC request, which carries the output port chosen by route computation.
- Grants one free VC of that output port's downstream router, answered on the status buffer's vc_New/vc_Val inputs.
- Tracks downstream VC ownership until the downstream router releases the VC after the tail flit drains.

---
 rtl/vc_allocator.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/vc_allocator.sv
// Router virtual-channel allocator: round-robin arbitration per output port,
// lowest-index free downstream VC granted, ownership held until released.
module vc_allocator #(
  parameter int NUM_PORTS = 5,
  parameter int NUM_VC    = 2,
  parameter int NUM_REQ   = NUM_PORTS * NUM_VC,
  parameter int VC_W      = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_i,
  input  logic [NUM_REQ*3-1:0]        req_port_i,
  input  logic [NUM_PORTS*NUM_VC-1:0] release_i,
  output logic [NUM_REQ-1:0]          grant_vld_o,
  output logic [NUM_REQ*VC_W-1:0]     grant_vc_o,
  output logic [NUM_PORTS*NUM_VC-1:0] free_vc_o,
  output logic                        err_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Round-robin pick: returns {found, index}; scanning downward lets the
  // requester nearest to ptr (in wrap order) overwrite the others.
  function automatic logic [PTR_W:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                             input logic [PTR_W-1:0]   ptr);
    logic [PTR_W:0] res;
    int             idx;
    res = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (elig[idx]) begin
        res = {1'b1, PTR_W'(idx)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Lowest-index free VC: returns {found, vc_index}.
  function automatic logic [VC_W:0] low_free(input logic [NUM_VC-1:0] free);
    logic [VC_W:0] res;
    res = '0;
    for (int v = NUM_VC - 1; v >= 0; v--) begin
      if (free[v]) begin
        res = {1'b1, VC_W'(v)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  logic [NUM_PORTS*NUM_VC-1:0] r_free;
  logic [NUM_REQ-1:0]          r_grant_vld;
  logic [NUM_REQ*VC_W-1:0]     r_grant_vc;
  logic                        r_err;
  logic [PTR_W-1:0]            r_ptr [NUM_PORTS];

  logic [NUM_REQ-1:0]          w_elig [NUM_PORTS];
  logic [PTR_W:0]              w_rr   [NUM_PORTS];
  logic [VC_W:0]               w_lf   [NUM_PORTS];
  logic [NUM_PORTS-1:0]        w_grant;
  logic [PTR_W-1:0]            w_ptr_nxt [NUM_PORTS];
  logic [NUM_PORTS*NUM_VC-1:0] w_alloc;
  logic [NUM_REQ-1:0]          w_gnt_vld_nxt;
  logic [NUM_REQ*VC_W-1:0]     w_gnt_vc_nxt;
  logic [NUM_PORTS*NUM_VC-1:0] w_free_nxt;
  logic                        w_bad_port;
  logic                        w_err;

  // Eligibility per port; a requester whose grant is currently visible is masked.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        w_elig[p][r] = req_i[r] && (int'(req_port_i[3*r +: 3]) == p) && !r_grant_vld[r];
      end
    end
  end

  // Per-port arbitration winner and candidate VC.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_rr[p]    = rr_pick(w_elig[p], r_ptr[p]);
      w_lf[p]    = low_free(r_free[p*NUM_VC +: NUM_VC]);
      w_grant[p] = w_rr[p][PTR_W] && w_lf[p][VC_W];
    end
  end

  // Build allocation mask, next grant vectors and pointer updates.
  always_comb begin
    w_alloc       = '0;
    w_gnt_vld_nxt = '0;
    w_gnt_vc_nxt  = r_grant_vc;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_ptr_nxt[p] = r_ptr[p];
      if (w_grant[p]) begin
        w_alloc[p*NUM_VC + int'(w_lf[p][VC_W-1:0])] = 1'b1;
        w_gnt_vld_nxt[int'(w_rr[p][PTR_W-1:0])]     = 1'b1;
        w_gnt_vc_nxt[int'(w_rr[p][PTR_W-1:0])*VC_W +: VC_W] = w_lf[p][VC_W-1:0];
        if (int'(w_rr[p][PTR_W-1:0]) == NUM_REQ - 1) begin
          w_ptr_nxt[p] = '0;
        end else begin
          w_ptr_nxt[p] = w_rr[p][PTR_W-1:0] + PTR_W'(1);
        end
      end else begin
        w_ptr_nxt[p] = r_ptr[p];
      end
    end
  end

  // Protocol errors: out-of-range port requests and releases of free VCs.
  always_comb begin
    w_bad_port = 1'b0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (req_i[r] && (int'(req_port_i[3*r +: 3]) >= NUM_PORTS)) begin
        w_bad_port = 1'b1;
      end else begin
        w_bad_port = w_bad_port;
      end
    end
    w_err      = w_bad_port || (|(release_i & r_free));
    w_free_nxt = (r_free & ~w_alloc) | release_i;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_free      <= '1;
      r_grant_vld <= '0;
      r_grant_vc  <= '0;
      r_err       <= 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_ptr[p] <= '0;
      end
    end else begin
      r_free      <= w_free_nxt;
      r_grant_vld <= w_gnt_vld_nxt;
      r_grant_vc  <= w_gnt_vc_nxt;
      r_err       <= w_err;
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_ptr[p] <= w_ptr_nxt[p];
      end
    end
  end

  assign grant_vld_o = r_grant_vld;
  assign grant_vc_o  = r_grant_vc;
  assign free_vc_o   = r_free;
  assign err_o       = r_err;

endmodule
